// File: rtl/updown_counter_ctrl_if.sv
// updown_counter_ctrl_if: command, count-tick and JK-bank signals of the up/down counter controller.
interface updown_counter_ctrl_if #(parameter int WIDTH = 8);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             en;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             dir;
    logic             tc;
    modport master(output cmd_valid, cmd_op, cmd_data, en, q_fb, input cmd_ready, j, k, dir, tc);
    modport slave(input cmd_valid, cmd_op, cmd_data, en, q_fb, output cmd_ready, j, k, dir, tc);
endinterface

// File: rtl/updown_counter_ctrl.sv
// updown_counter_ctrl: computes per-bit J/K drives for a JK flip-flop bank acting as an up/down counter
// with hold, up, down, bounce, load and clear, plus limit/wrap/saturate handling.
module updown_counter_ctrl #(
    parameter int WIDTH = 8,
    parameter bit WRAP  = 1'b1
) (
    input logic              clk,
    input logic              reset,
    updown_counter_ctrl_if.slave bus
);
    localparam logic [2:0] OP_UP = 3'd1, OP_DOWN = 3'd2, OP_BOUNCE = 3'd3,
                           OP_LOAD = 3'd4, OP_CLEAR = 3'd5, OP_SETLIM = 3'd6;
    localparam logic [1:0] M_HOLD = 2'd0, M_UP = 2'd1, M_DOWN = 2'd2, M_BOUNCE = 2'd3;
    localparam logic [1:0] S_RUN = 2'd0, S_LOAD = 2'd1, S_CLR = 2'd2;

    logic [1:0]       mode, ret_mode, state;
    logic             dir_r, flip, accept;
    logic [WIDTH-1:0] limit, ld_val, q, up_t, dn_t;

    // Bit i toggles when every lower bit of v is zero; feed ~q for up, q for down.
    function automatic logic [WIDTH-1:0] toggles(input logic [WIDTH-1:0] v);
        toggles = '0;
        for (int i = 0; i < WIDTH; i++)
            toggles[i] = (v & ((WIDTH'(1) << i) - WIDTH'(1))) == '0;
    endfunction

    assign q             = bus.q_fb;
    assign up_t          = toggles(~q);
    assign dn_t          = toggles(q);
    assign bus.cmd_ready = state == S_RUN;
    assign bus.dir       = dir_r;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        bus.j  = '0;
        bus.k  = '0;
        bus.tc = 1'b0;
        flip   = 1'b0;
        if (state == S_LOAD) begin
            bus.j = ld_val;
            bus.k = ~ld_val;
        end else if (state == S_CLR) begin
            bus.k = '1;
        end else if (bus.en) begin
            case (mode)
                M_UP: begin
                    bus.tc = q >= limit;
                    bus.j  = bus.tc ? '0 : up_t;
                    bus.k  = bus.tc ? {WIDTH{WRAP}} : up_t;
                end
                M_DOWN: begin
                    bus.tc = q == '0;
                    bus.j  = bus.tc ? limit & {WIDTH{WRAP}} : dn_t;
                    bus.k  = bus.tc ? ~limit & {WIDTH{WRAP}} : dn_t;
                end
                M_BOUNCE: begin
                    // Overshoot above the limit, or a zero limit, is pinned by loading the limit.
                    if ((dir_r && q > limit) || (limit == '0 && q == '0)) begin
                        bus.j = limit;
                        bus.k = ~limit;
                    end else begin
                        bus.j = (dir_r ? q < limit : q == '0) ? up_t : dn_t;
                        bus.k = bus.j;
                    end
                    bus.tc = dir_r ? q >= limit : q == '0;
                    flip   = bus.tc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode     <= M_HOLD;
            ret_mode <= M_HOLD;
            state    <= S_RUN;
            dir_r    <= 1'b1;
            limit    <= '1;
            ld_val   <= '0;
        end else if (state != S_RUN) begin
            state <= S_RUN;
            mode  <= ret_mode;
        end else begin
            if (flip)
                dir_r <= ~dir_r;
            if (accept) begin
                case (bus.cmd_op)
                    OP_UP: begin
                        mode  <= M_UP;
                        dir_r <= 1'b1;
                    end
                    OP_DOWN: begin
                        mode  <= M_DOWN;
                        dir_r <= 1'b0;
                    end
                    OP_BOUNCE: mode <= M_BOUNCE;
                    OP_LOAD: begin
                        ld_val   <= bus.cmd_data;
                        ret_mode <= mode;
                        state    <= S_LOAD;
                    end
                    OP_CLEAR: begin
                        ret_mode <= mode;
                        state    <= S_CLR;
                    end
                    OP_SETLIM: limit <= bus.cmd_data;
                    default: mode <= M_HOLD;
                endcase
            end
        end
    end
endmodule
